// File: rtl/lsu_mem_if.sv
// Load/store unit memory-port initiator: one core request in, one or two word accesses out,
// one response back with aligned, extended load data.
//
// state | meaning
// IDLE  | ready for a core request
// REQ0  | first (or only) word access presented, waiting for mem_gnt
// WAIT0 | load: waiting for read data of the first word
// REQ1  | second word access of an access that crosses a word boundary
// WAIT1 | load: waiting for read data of the second word
// RESP  | one-cycle response to the core
module lsu_mem_if #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata0_q;
    logic [23:0] rdata1_q;

    logic        accept;
    logic        req_illegal;
    logic        req_cross;
    logic        req_err;

    logic [7:0]  mask8;
    logic        split;
    logic [31:0] word_addr;
    logic [63:0] wdata64;
    logic [31:0] rd_word;
    logic [31:0] load_ext;

    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // Request decode at acceptance time; the error decision is captured with the request.
    always_comb begin
        req_illegal = (req_funct3[1:0] == 2'b11)
                   || (!req_we && (req_funct3 == 3'b110))
                   || (req_we && req_funct3[2]);
        case (req_funct3[1:0])
            2'b00:   req_cross = 1'b0;
            2'b01:   req_cross = (req_addr[1:0] == 2'b11);
            default: req_cross = (req_addr[1:0] != 2'b00);
        endcase
        req_err = req_illegal || (!SPLIT_EN && req_cross);
    end

    assign mask8     = {4'b0000, size_mask(funct3_q[1:0])} << addr_q[1:0];
    assign split     = |mask8[7:4];
    assign word_addr = {addr_q[31:2], 2'b00};
    assign wdata64   = {32'h0000_0000, wdata_q} << {addr_q[1:0], 3'b000};

    // Right-align the addressed bytes from the two captured read words.
    always_comb begin
        case (addr_q[1:0])
            2'b00:   rd_word = rdata0_q;
            2'b01:   rd_word = {rdata1_q[7:0],  rdata0_q[31:8]};
            2'b10:   rd_word = {rdata1_q[15:0], rdata0_q[31:16]};
            default: rd_word = {rdata1_q[23:0], rdata0_q[31:24]};
        endcase
    end

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   load_ext = funct3_q[2] ? {24'h000000, rd_word[7:0]}
                                            : {{24{rd_word[7]}}, rd_word[7:0]};
            2'b01:   load_ext = funct3_q[2] ? {16'h0000, rd_word[15:0]}
                                            : {{16{rd_word[15]}}, rd_word[15:0]};
            default: load_ext = rd_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0000_0000;
            wdata_q  <= 32'h0000_0000;
            err_q    <= 1'b0;
            rdata0_q <= 32'h0000_0000;
            rdata1_q <= 24'h000000;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                err_q    <= req_err;
                rdata0_q <= 32'h0000_0000;
                rdata1_q <= 24'h000000;
            end
            if ((state == WAIT0) && mem_rvalid) begin
                rdata0_q <= mem_rdata;
            end
            if ((state == WAIT1) && mem_rvalid) begin
                rdata1_q <= mem_rdata[23:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = req_err ? RESP : REQ0;
                end
            end
            REQ0: begin
                if (mem_gnt) begin
                    if (!we_q) begin
                        state_nxt = WAIT0;
                    end else begin
                        state_nxt = split ? REQ1 : RESP;
                    end
                end
            end
            WAIT0: begin
                if (mem_rvalid) begin
                    state_nxt = split ? REQ1 : RESP;
                end
            end
            REQ1: begin
                if (mem_gnt) begin
                    state_nxt = we_q ? RESP : WAIT1;
                end
            end
            WAIT1: begin
                if (mem_rvalid) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the state and the captured request, so they hold
    // steady while a request waits for its grant. Reset forces them all low.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 4'b0000;
        mem_addr   = 32'h0000_0000;
        mem_wdata  = 32'h0000_0000;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'h0000_0000;
        if (!rst) begin
            case (state)
                REQ0: begin
                    mem_req   = 1'b1;
                    mem_we    = we_q;
                    mem_be    = mask8[3:0];
                    mem_addr  = word_addr;
                    mem_wdata = we_q ? wdata64[31:0] : 32'h0000_0000;
                end
                REQ1: begin
                    mem_req   = 1'b1;
                    mem_we    = we_q;
                    mem_be    = mask8[7:4];
                    mem_addr  = word_addr + 32'd4;
                    mem_wdata = we_q ? wdata64[63:32] : 32'h0000_0000;
                end
                RESP: begin
                    resp_valid = 1'b1;
                    resp_err   = err_q;
                    resp_rdata = (err_q || we_q) ? 32'h0000_0000 : load_ext;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Bench for lsu_mem_if: directed cases plus random loads/stores against a byte-array
// memory model; a responder process plays the memory with configurable grant/read delays.
module tb_lsu_mem_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    // second instance with splitting disabled
    logic        ns_req_valid, ns_req_ready, ns_req_we;
    logic [2:0]  ns_req_funct3;
    logic [31:0] ns_req_addr, ns_req_wdata;
    logic        ns_resp_valid, ns_resp_err;
    logic [31:0] ns_resp_rdata;
    logic        ns_mem_req, ns_mem_gnt, ns_mem_we, ns_mem_rvalid;
    logic [3:0]  ns_mem_be;
    logic [31:0] ns_mem_addr, ns_mem_wdata, ns_mem_rdata;

    lsu_mem_if #(.SPLIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    lsu_mem_if #(.SPLIT_EN(1'b0)) dut_ns (
        .clk(clk), .rst(rst),
        .req_valid(ns_req_valid), .req_ready(ns_req_ready), .req_we(ns_req_we),
        .req_funct3(ns_req_funct3), .req_addr(ns_req_addr), .req_wdata(ns_req_wdata),
        .resp_valid(ns_resp_valid), .resp_err(ns_resp_err), .resp_rdata(ns_resp_rdata),
        .mem_req(ns_mem_req), .mem_gnt(ns_mem_gnt), .mem_we(ns_mem_we), .mem_be(ns_mem_be),
        .mem_addr(ns_mem_addr), .mem_wdata(ns_mem_wdata),
        .mem_rvalid(ns_mem_rvalid), .mem_rdata(ns_mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // memory seen by the DUT, and the reference byte image
    logic [31:0] mem_words [0:255];
    logic [7:0]  ref_mem   [0:1023];

    int gnt_cfg = 0;
    int rd_cfg  = 1;
    logic [31:0] q_addr[$];
    logic [31:0] q_wdata[$];
    logic [3:0]  q_be[$];

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        mem_words[a[9:2]] = v;
        for (int i = 0; i < 4; i++) ref_mem[{a[9:2], 2'b00} + i] = v[8*i +: 8];
    endtask

    // memory responder
    initial begin
        int          wait_left;
        bit          armed;
        int          rd_cnt;
        logic [7:0]  rd_idx;
        bit          prev_wait;
        logic [31:0] prev_addr, prev_wdata;
        logic [3:0]  prev_be;
        logic        prev_we;
        armed = 0; wait_left = 0; rd_cnt = 0; rd_idx = 0; prev_wait = 0;
        prev_addr = 0; prev_wdata = 0; prev_be = 0; prev_we = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        forever begin
            @(negedge clk);
            #1;
            mem_gnt = 0;
            mem_rvalid = 0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    mem_rvalid = 1;
                    mem_rdata  = mem_words[rd_idx];
                end
            end
            if (rst) begin
                armed = 0;
                prev_wait = 0;
            end else if (mem_req) begin
                if (prev_wait) begin
                    chk("stable_addr", mem_addr, prev_addr);
                    chk("stable_be", {28'h0, mem_be}, {28'h0, prev_be});
                    chk("stable_we_wdata", mem_wdata ^ {31'h0, mem_we}, prev_wdata ^ {31'h0, prev_we});
                end
                if (!armed) begin
                    armed = 1;
                    wait_left = gnt_cfg;
                end
                if (wait_left > 0) begin
                    wait_left--;
                    prev_wait = 1;
                    prev_addr = mem_addr; prev_be = mem_be;
                    prev_wdata = mem_wdata; prev_we = mem_we;
                end else begin
                    mem_gnt = 1;
                    armed = 0;
                    prev_wait = 0;
                    q_addr.push_back(mem_addr);
                    q_be.push_back(mem_be);
                    q_wdata.push_back(mem_wdata);
                    if (mem_we) begin
                        for (int i = 0; i < 4; i++)
                            if (mem_be[i]) mem_words[mem_addr[9:2]][8*i +: 8] = mem_wdata[8*i +: 8];
                    end else begin
                        rd_cnt = rd_cfg;
                        rd_idx = mem_addr[9:2];
                    end
                end
            end else begin
                prev_wait = 0;
            end
        end
    end

    // reference model
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit ref_illegal(input logic we, input logic [2:0] f3);
        return (f3[1:0] == 2'b11) || (!we && f3 == 3'b110) || (we && f3[2]);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] v;
        int n;
        n = nbytes(f3);
        v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a[9:0] + i]) << (8 * i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 1);
        return v;
    endfunction

    logic        r_got;
    int          r_lat;
    logic        r_err;
    logic [31:0] r_rdata;

    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
        int c0;
        bit rdy;
        q_addr.delete(); q_be.delete(); q_wdata.delete();
        r_got = 0; r_lat = 0; r_err = 0; r_rdata = 0;
        rdy = 0;
        for (int i = 0; i < 20 && !rdy; i++) begin
            @(negedge clk);
            #2;
            rdy = req_ready;
        end
        chk("ready_timeout", {31'h0, rdy}, 32'd1);
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        c0 = cyc;
        for (int i = 0; i < 200 && !r_got; i++) begin
            @(negedge clk);
            #2;
            req_valid = 0;
            if (resp_valid) begin
                r_got = 1; r_lat = cyc - c0; r_err = resp_err; r_rdata = resp_rdata;
            end
        end
        chk("resp_timeout", {31'h0, r_got}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a, wd, exp_rd;
        bit          e_err;
        int          n, ng;

        rst = 1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        ns_req_valid = 0; ns_req_we = 0; ns_req_funct3 = 0; ns_req_addr = 0; ns_req_wdata = 0;
        ns_mem_gnt = 1; ns_mem_rvalid = 0; ns_mem_rdata = 0;
        for (int i = 0; i < 256; i++) set_word(32'(i * 4), $urandom);

        repeat (2) @(negedge clk);
        #2;
        chk("rst_req_ready", {31'h0, req_ready}, 32'd0);
        chk("rst_mem_req", {31'h0, mem_req}, 32'd0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        chk("rst_mem_be_addr", {28'h0, mem_be} | mem_addr, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        rst = 0;

        // 1: aligned LW, best case
        set_word(32'h100, 32'hDEADBEEF);
        run_req(0, 3'b010, 32'h100, 0);
        chk("lw_rdata", r_rdata, 32'hDEADBEEF);
        chk("lw_lat", r_lat, 3);
        chk("lw_ngnt", q_addr.size(), 1);
        if (q_addr.size() == 1) begin
            chk("lw_addr", q_addr[0], 32'h100);
            chk("lw_be", {28'h0, q_be[0]}, 32'hF);
        end

        // 2: LB / LBU top byte
        set_word(32'h100, 32'h80123456);
        run_req(0, 3'b000, 32'h103, 0);
        chk("lb_rdata", r_rdata, 32'hFFFFFF80);
        if (q_be.size() == 1) chk("lb_be", {28'h0, q_be[0]}, 32'h8);
        run_req(0, 3'b100, 32'h103, 0);
        chk("lbu_rdata", r_rdata, 32'h00000080);

        // 3: split LW
        set_word(32'h0FC, 32'hBBAA1122);
        set_word(32'h100, 32'h3344DDCC);
        run_req(0, 3'b010, 32'h0FE, 0);
        chk("split_lw_rdata", r_rdata, 32'hDDCCBBAA);
        chk("split_lw_lat", r_lat, 5);
        chk("split_lw_ngnt", q_addr.size(), 2);
        if (q_addr.size() == 2) begin
            chk("split_lw_be0", {28'h0, q_be[0]}, 32'hC);
            chk("split_lw_be1", {28'h0, q_be[1]}, 32'h3);
            chk("split_lw_addr1", q_addr[1], 32'h100);
        end

        // 4: split SH
        run_req(1, 3'b001, 32'h203, 32'h00001234);
        for (int i = 0; i < 2; i++) ref_mem[32'h203 + i] = (i == 0) ? 8'h34 : 8'h12;
        chk("sh_lat", r_lat, 3);
        chk("sh_rdata", r_rdata, 32'd0);
        chk("sh_ngnt", q_addr.size(), 2);
        if (q_addr.size() == 2) begin
            chk("sh_addr0", q_addr[0], 32'h200);
            chk("sh_be0", {28'h0, q_be[0]}, 32'h8);
            chk("sh_wd0", {24'h0, q_wdata[0][31:24]}, 32'h34);
            chk("sh_addr1", q_addr[1], 32'h204);
            chk("sh_be1", {28'h0, q_be[1]}, 32'h1);
            chk("sh_wd1", {24'h0, q_wdata[1][7:0]}, 32'h12);
        end
        run_req(0, 3'b101, 32'h203, 0);
        chk("sh_readback", r_rdata, 32'h00001234);

        // 5: grant held off five cycles
        gnt_cfg = 5;
        set_word(32'h100, 32'h01234567);
        run_req(0, 3'b010, 32'h100, 0);
        chk("stall_rdata", r_rdata, 32'h01234567);
        chk("stall_lat", r_lat, 8);
        chk("stall_ngnt", q_addr.size(), 1);
        gnt_cfg = 0;

        // 6: illegal funct3, and crossing access with splitting disabled
        run_req(0, 3'b011, 32'h100, 0);
        chk("ill_err", {31'h0, r_err}, 32'd1);
        chk("ill_lat", r_lat, 1);
        chk("ill_ngnt", q_addr.size(), 0);
        chk("ill_rdata", r_rdata, 32'd0);

        @(negedge clk);
        ns_req_valid = 1; ns_req_we = 0; ns_req_funct3 = 3'b010; ns_req_addr = 32'h101;
        #2 chk("ns_ready", {31'h0, ns_req_ready}, 32'd1);
        @(negedge clk);
        ns_req_valid = 0;
        #2;
        chk("ns_resp_valid", {31'h0, ns_resp_valid}, 32'd1);
        chk("ns_resp_err", {31'h0, ns_resp_err}, 32'd1);
        chk("ns_no_mem_req", {31'h0, ns_mem_req}, 32'd0);
        @(negedge clk);
        ns_req_valid = 1; ns_req_we = 1; ns_req_funct3 = 3'b001; ns_req_addr = 32'h102;
        ns_req_wdata = 32'hABCD;
        @(negedge clk);
        ns_req_valid = 0;
        #2;
        chk("ns_sh_mem_req", {31'h0, ns_mem_req}, 32'd1);
        chk("ns_sh_be", {28'h0, ns_mem_be}, 32'hC);
        @(negedge clk);
        #2;
        chk("ns_sh_resp", {ns_resp_valid, ns_resp_err}, 32'd2);

        // 7: reset during WAIT0, stale rvalid afterwards
        rd_cfg = 3;
        @(negedge clk);
        req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h100;
        #2 chk("rst7_ready", {31'h0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        rst = 1;
        #2;
        chk("rst7_req_ready", {31'h0, req_ready}, 32'd0);
        chk("rst7_mem_req", {31'h0, mem_req}, 32'd0);
        chk("rst7_resp_valid", {31'h0, resp_valid}, 32'd0);
        @(negedge clk);
        rst = 0;
        #2 chk("rst7_ready_after", {31'h0, req_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #2 chk("rst7_no_resp", {31'h0, resp_valid}, 32'd0);
        end
        rd_cfg = 1;

        // random traffic against the byte-array model
        for (int k = 0; k < 150; k++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'h100 + 32'($urandom_range(0, 63));
            wd = $urandom;
            gnt_cfg = $urandom_range(0, 3);
            rd_cfg  = $urandom_range(1, 3);
            e_err = ref_illegal(we, f3);
            n  = nbytes(f3);
            ng = e_err ? 0 : (((a % 4) + n > 4) ? 2 : 1);
            exp_rd = (!we && !e_err) ? ref_load(a, f3) : 32'd0;
            run_req(we, f3, a, wd);
            chk("rnd_err", {31'h0, r_err}, {31'h0, e_err});
            chk("rnd_rdata", r_rdata, exp_rd);
            chk("rnd_ngnt", q_addr.size(), ng);
            for (int j = 0; j < ng && j < q_addr.size(); j++) begin
                logic [31:0] base;
                logic [3:0]  ebe;
                base = (a & ~32'd3) + 32'(4 * j);
                for (int i = 0; i < 4; i++) ebe[i] = (base + i >= a) && (base + i < a + n);
                chk("rnd_addr", q_addr[j], base);
                chk("rnd_be", {28'h0, q_be[j]}, {28'h0, ebe});
            end
            if (we && !e_err) begin
                for (int i = 0; i < n; i++) ref_mem[a[9:0] + i] = wd[8*i +: 8];
                for (int j = 0; j < ng; j++) begin
                    logic [31:0] base;
                    base = (a & ~32'd3) + 32'(4 * j);
                    chk("rnd_memword", mem_words[base[9:2]],
                        {ref_mem[base[9:0] + 3], ref_mem[base[9:0] + 2],
                         ref_mem[base[9:0] + 1], ref_mem[base[9:0]]});
                end
            end
            if (gnt_cfg == 0 && rd_cfg == 1)
                chk("rnd_lat", r_lat, e_err ? 1 : (we ? 1 + ng : 1 + 2 * ng));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
